// File: rtl/cache_pkg.sv
// Shared types and constants for the L2<->MEM line-transfer path.
package cache_pkg;

   localparam int BEATS           = 8;
   localparam int WORD_W          = 32;
   localparam int LINE_OFFSET_LSB = 2;
   localparam int LINE_OFFSET_W   = 3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BURST,
      DONE
   } state_t;

   // Word offset within the line for beat k; wraps inside the line.
   function automatic logic [LINE_OFFSET_W-1:0] beat_offset(
      input logic [LINE_OFFSET_W-1:0] start,
      input logic [3:0]               k
   );
      return start + k[LINE_OFFSET_W-1:0];
   endfunction

endpackage

// File: rtl/mem_burst_if.sv
// L2<->MEM burst bus: L2 is the master, the memory responder the slave.
interface mem_burst_if;
   import cache_pkg::*;

   logic              req;
   logic              we_MEM;
   logic [WORD_W-1:0] addr_MEM;
   logic [WORD_W-1:0] data_MEM_in;
   logic [WORD_W-1:0] data_MEM_out;
   logic              data_MEM_oe;
   logic              stb;
   logic              busy;
   logic              done;

   modport master (
      output req, we_MEM, addr_MEM, data_MEM_in,
      input  data_MEM_out, data_MEM_oe, stb, busy, done
   );

   modport slave (
      input  req, we_MEM, addr_MEM, data_MEM_in,
      output data_MEM_out, data_MEM_oe, stb, busy, done
   );

endinterface

// File: rtl/mem_word_array.sv
// Single-port word array: synchronous write, combinational read.
module mem_word_array #(
   parameter int MEM_WORDS = 1024,
   parameter int AW        = 10
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_burst_responder.sv
// Memory end of the L2<->MEM link: 8-beat bursts, one stb toggle per beat.
// Define MEM_CRITICAL_WORD_FIRST_EN to start each burst at the requested word.
module mem_burst_responder #(
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 4,
   parameter int BEATS     = 8
) (
   input logic       clk,
   input logic       reset,
   mem_burst_if.slave bus
);
   import cache_pkg::*;

   localparam int AW = $clog2(MEM_WORDS);

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic [3:0]          r_beat;
   logic                r_rd;
   logic [AW-1:0]       r_base;
   logic [2:0]          r_start;
   logic                r_stb;
   logic                r_busy;
   logic                r_done;
   logic                r_oe;
   logic [WORD_W-1:0]   r_dout;

   logic [AW-1:0]       w_acc_idx;
   logic [2:0]          w_acc_start;
   logic [AW-1:0]       w_idx;
   logic                w_in_beat;
   logic                w_we;
   logic [WORD_W-1:0]   w_rdata;
   logic                w_unused_addr;

   assign w_acc_idx = bus.addr_MEM[AW+1:LINE_OFFSET_LSB];

`ifdef MEM_CRITICAL_WORD_FIRST_EN
   assign w_acc_start = bus.addr_MEM[4:2];
`else
   assign w_acc_start = 3'd0;
`endif

   assign w_unused_addr = ^bus.addr_MEM;

   assign w_idx = r_base | AW'(beat_offset(r_start, r_beat));
   assign w_in_beat = (r_state == BURST) && (r_beat < 4'(BEATS));
   // Reset wins over a pending beat so an aborted write stops cleanly.
   assign w_we = w_in_beat && !r_rd && !reset;

   mem_word_array #(
      .MEM_WORDS (MEM_WORDS),
      .AW        (AW)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_idx),
      .i_wdata (bus.data_MEM_in),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_beat  <= '0;
         r_rd    <= 1'b0;
         r_base  <= '0;
         r_start <= '0;
         r_stb   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_oe    <= 1'b0;
         r_dout  <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.req) begin
                  r_rd    <= bus.we_MEM;
                  r_base  <= w_acc_idx & ~AW'(7);
                  r_start <= w_acc_start;
                  r_busy  <= 1'b1;
                  r_cnt   <= 4'(LATENCY);
                  r_beat  <= '0;
                  r_state <= (LATENCY == 0) ? BURST : WAIT;
               end
            end
            WAIT: begin
               if (r_cnt <= 4'd1) begin
                  r_cnt   <= '0;
                  r_state <= BURST;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            BURST: begin
               if (w_in_beat) begin
                  r_stb  <= ~r_stb;
                  r_beat <= r_beat + 4'd1;
                  if (r_rd) begin
                     r_oe   <= 1'b1;
                     r_dout <= w_rdata;
                  end
               end else begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_oe    <= 1'b0;
                  r_beat  <= '0;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (!bus.req) begin
                  r_done  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.stb          = r_stb;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.data_MEM_oe  = r_oe;
   assign bus.data_MEM_out = r_dout;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Scoreboard bench for mem_burst_responder against a word-array reference.
module tb_mem_burst_responder;

   localparam int MW  = 1024;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_burst_if bus ();
   mem_burst_if bus0 ();

   mem_burst_responder #(
      .MEM_WORDS (MW),
      .LATENCY   (LAT),
      .BEATS     (8)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   mem_burst_responder #(
      .MEM_WORDS (MW),
      .LATENCY   (0),
      .BEATS     (8)
   ) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   typedef struct {
      bit          rd;
      int          idx;
      logic [31:0] wdata;
      int          k;
   } beat_t;

   logic [31:0] model [MW];
   beat_t       exp_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [31:0] wbuf [8];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic int beat_idx(input logic [31:0] addr, input int k);
      int word;
      int base;
      int off;
      word = int'(addr[31:2]) % MW;
      base = word - (word % 8);
      off  = 0;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
      off = word % 8;
`endif
      return base + ((off + k) % 8);
   endfunction

   // Monitor: pops one expected beat per observed stb toggle.
   logic  p_stb  = 1'b0;
   logic  p_busy = 1'b0;
   logic  p_done = 1'b0;
   int    t_acc  = 0;
   int    last_k = -1;
   beat_t e;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         exp_q.delete();
         last_k = -1;
      end else begin
         if (bus.busy && !p_busy) begin
            t_acc  = cyc;
            last_k = -1;
         end
         if (bus.stb !== p_stb) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL stray_stb: got toggle expected none (cycle %0d)",
                        cyc);
            end else begin
               e = exp_q.pop_front();
               chk("beat_time", cyc - t_acc, LAT + 1 + e.k);
               chk("beat_oe", bus.data_MEM_oe, {31'd0, e.rd});
               if (e.rd) chk("rdata", bus.data_MEM_out, model[e.idx]);
               else model[e.idx] = e.wdata;
               last_k = e.k;
            end
         end
         if (bus.done && !p_done) begin
            chk("done_time", cyc - t_acc, LAT + 9);
            chk("beats_seen", last_k, 7);
            chk("busy_at_done", bus.busy, 0);
            chk("oe_at_done", bus.data_MEM_oe, 0);
         end
      end
      p_stb  = bus.stb;
      p_busy = bus.busy;
      p_done = bus.done;
   end

   task automatic do_txn(input bit rd, input logic [31:0] addr,
                         input logic [31:0] w [8], input bit early);
      int   n;
      int   t;
      logic p;
      @(negedge clk);
      for (int k = 0; k < 8; k++)
         exp_q.push_back('{rd, beat_idx(addr, k), w[k], k});
      bus.we_MEM      = rd;
      bus.addr_MEM    = addr;
      bus.data_MEM_in = w[0];
      bus.req         = 1'b1;
      n = 0;
      t = 0;
      p = bus.stb;
      while (n < 8 && t < 64) begin
         @(negedge clk);
         t++;
         if (t == 1) begin
            bus.addr_MEM = $urandom;
            bus.we_MEM   = 1'($urandom);
         end
         if (early && t == 2) bus.req = 1'b0;
         if (bus.stb !== p) begin
            p = bus.stb;
            n++;
            if (n < 8) bus.data_MEM_in = w[n];
         end
      end
      chk("burst_beats", n, 8);
      t = 0;
      while (!bus.done && t < 8) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", bus.done, 1);
      bus.req = 1'b0;
      @(negedge clk);
      chk("done_drop", bus.done, 0);
      chk("busy_idle", bus.busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int   n;
      int   t;
      logic p;
      logic [31:0] a;
      bit   rd;
      bus.req = 0; bus.we_MEM = 0; bus.addr_MEM = 0; bus.data_MEM_in = 0;
      bus0.req = 0; bus0.we_MEM = 0; bus0.addr_MEM = 0; bus0.data_MEM_in = 0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_stb", bus.stb, 0);
         chk("idle_busy", bus.busy, 0);
         chk("idle_done", bus.done, 0);
         chk("idle_oe", bus.data_MEM_oe, 0);
      end

      for (int l = 0; l < MW / 8; l++) begin
         for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
         do_txn(1'b0, 32'(l * 32), wbuf, 1'b0);
      end

      for (int k = 0; k < 8; k++) wbuf[k] = 32'hA0 + 32'(k);
      do_txn(1'b0, 32'h100, wbuf, 1'b0);
      do_txn(1'b1, 32'h104, wbuf, 1'b0);

      for (int k = 0; k < 8; k++) wbuf[k] = 32'hB0 + 32'(k);
      do_txn(1'b0, 32'h200, wbuf, 1'b0);
      do_txn(1'b1, 32'h200, wbuf, 1'b0);

      for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
      do_txn(1'b0, 32'hFFFF_FFE0, wbuf, 1'b0);
      do_txn(1'b1, 32'hFFFF_FFE0, wbuf, 1'b0);
      do_txn(1'b1, 32'hFFFF_FFFC, wbuf, 1'b0);
      do_txn(1'b1, 32'h0, wbuf, 1'b0);

      // Abort a write with reset at beat 3.
      for (int k = 0; k < 8; k++) wbuf[k] = 32'hC0 + 32'(k);
      @(negedge clk);
      for (int k = 0; k < 8; k++)
         exp_q.push_back('{1'b0, beat_idx(32'h300, k), wbuf[k], k});
      bus.we_MEM = 1'b0; bus.addr_MEM = 32'h300;
      bus.data_MEM_in = wbuf[0]; bus.req = 1'b1;
      n = 0; t = 0; p = bus.stb;
      while (n < 3 && t < 64) begin
         @(negedge clk);
         t++;
         if (bus.stb !== p) begin
            p = bus.stb;
            n++;
            bus.data_MEM_in = wbuf[n];
         end
      end
      chk("pre_reset_beats", n, 3);
      #1;
      reset = 1'b1;
      bus.req = 1'b0;
      @(negedge clk);
      chk("rst_stb", bus.stb, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_oe", bus.data_MEM_oe, 0);
      chk("rst_dout", bus.data_MEM_out, 0);
      @(negedge clk);
      reset = 1'b0;
      do_txn(1'b1, 32'h300, wbuf, 1'b0);

      a = 32'h0;
      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 1) begin
            rd = 1'b1;
         end else begin
            rd = 1'($urandom);
            a  = $urandom;
         end
         for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
         do_txn(rd, a, wbuf, ($urandom % 4) == 0);
         repeat ($urandom % 3) @(negedge clk);
      end

      // Zero-latency instance: req held high through DONE.
      for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
      @(negedge clk);
      bus0.we_MEM = 1'b0; bus0.addr_MEM = 32'h40;
      bus0.data_MEM_in = wbuf[0]; bus0.req = 1'b1;
      @(negedge clk);
      chk("l0_accept", bus0.busy, 1);
      p = bus0.stb;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("l0_wr_toggle", {31'd0, bus0.stb !== p}, 1);
         p = bus0.stb;
         if (k < 7) bus0.data_MEM_in = wbuf[k + 1];
      end
      @(negedge clk);
      chk("l0_done", bus0.done, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("l0_hold_done", bus0.done, 1);
         chk("l0_no_accept", bus0.busy, 0);
      end
      bus0.req = 1'b0;
      @(negedge clk);
      chk("l0_done_drop", bus0.done, 0);
      chk("l0_busy_low", bus0.busy, 0);
      bus0.we_MEM = 1'b1; bus0.req = 1'b1;
      @(negedge clk);
      chk("l0_accept2", bus0.busy, 1);
      p = bus0.stb;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("l0_rd_toggle", {31'd0, bus0.stb !== p}, 1);
         chk("l0_rd_oe", bus0.data_MEM_oe, 1);
         chk("l0_rdata", bus0.data_MEM_out, wbuf[beat_idx(32'h40, k) - 16]);
         p = bus0.stb;
      end
      @(negedge clk);
      chk("l0_done2", bus0.done, 1);
      bus0.req = 1'b0;
      @(negedge clk);
      chk("l0_done2_drop", bus0.done, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
